// File: rtl/stage_fetch_pkg.sv
// Shared fetch-stage definitions: word width, NOP encoding, FSM states and buffer entry layout.
package stage_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  typedef enum logic [2:0] {
    ITYPE_ALU    = 3'd0,
    ITYPE_LOAD   = 3'd1,
    ITYPE_STORE  = 3'd2,
    ITYPE_BRANCH = 3'd3,
    ITYPE_JUMP   = 3'd4
  } instr_type_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/stage_fetch_buffer.sv
// Small FIFO of {pc, instr}; flush beats push/pop, head read combinationally from registered storage.
// Push into a full buffer is legal only together with a pop.
module fetch_buffer
  import stage_fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_dat_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  assign do_pop = pop_i && (count_q != '0);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end

  // When full, push and pop hit the same slot; the old head is read before the edge.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/stage_fetch.sv
// Fetch stage: PC, single-outstanding imem read FSM, redirect/flush, instruction buffer to decode.
// Word visible one cycle after its rvalid; stall holds the head, requests continue while room remains.
module stage_fetch
  import stage_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump_valid,
  input  logic [31:0] forwarded_jump_condition,
  input  logic [31:0] forwarded_jump_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] current_instruction,
  output logic [31:0] current_pc,
  output logic        fetch_valid
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          redirect;
  logic          accept;
  logic          push;
  logic          pop;
  logic          room;
  logic [CW:0]   inflight;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_dat;

  assign redirect = jump_valid && (forwarded_jump_condition != '0);
  assign pop      = fetch_valid && !stall;
  // An outstanding WAIT request already owns a buffer slot.
  assign inflight = {1'b0, count} + (CW+1)'(state_q == FETCH_WAIT);
  assign room     = inflight < (CW+1)'(BUF_DEPTH);
  assign imem_req = !rst && (state_q == FETCH_IDLE) && room && !redirect;
  assign accept   = imem_req && imem_ready;
  assign imem_addr = pc_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;
    unique case (state_q)
      FETCH_IDLE: begin
        if (accept) begin
          state_d  = FETCH_WAIT;
          pc_d     = pc_q + 32'd1;
          req_pc_d = pc_q;
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          state_d = FETCH_IDLE;
          push    = !redirect;
        end else if (redirect) begin
          state_d = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        if (imem_rvalid) state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
    if (redirect) pc_d = forwarded_jump_address;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign push_dat = '{pc: req_pc_q, instr: imem_rdata};

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .flush_i    (redirect),
    .head_o     (head),
    .count_o    (count)
  );

  assign fetch_valid         = (count != '0);
  assign current_instruction = fetch_valid ? head.instr : NOP_INSTR;
  assign current_pc          = fetch_valid ? head.pc : '0;

endmodule

// File: tb/tb_stage_fetch.sv
// Randomized scoreboard bench for stage_fetch with an in-order imem model and a PC-stream reference.
module tb_stage_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam int          BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        jump_valid = 1'b0;
  logic [31:0] cond = '0;
  logic [31:0] jaddr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] current_instruction;
  logic [31:0] current_pc;
  logic        fetch_valid;

  stage_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .stall                    (stall),
    .jump_valid               (jump_valid),
    .forwarded_jump_condition (cond),
    .forwarded_jump_address   (jaddr),
    .imem_req                 (imem_req),
    .imem_addr                (imem_addr),
    .imem_ready               (imem_ready),
    .imem_rvalid              (imem_rvalid),
    .imem_rdata               (imem_rdata),
    .current_instruction      (current_instruction),
    .current_pc               (current_pc),
    .fetch_valid              (fetch_valid)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int n_cons = 0;

  // Stimulus knobs
  int stall_pct = 0, jump_pct = 0, taken_pct = 50, rdy_pct = 100;
  int k_min = 1, k_max = 1;

  // Reference model: program order of the words decode should consume
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_ins_q[$];
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] want_req_addr = RESET_PC;
  bit          want_req_chk = 1'b0;

  // imem model state
  int unsigned pend_due[$];
  logic [31:0] pend_addr[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'd100;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction memory: in-order responses k cycles after accept.
  always begin
    int unsigned due;
    @(posedge clk);
    #1;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_ready = ($urandom_range(0, 99) < rdy_pct);
    #4;
    if (imem_req && imem_ready) begin
      check("one_outstanding", pend_due.size(), 0);
      if (want_req_chk) begin
        check("req_addr_after_redirect", imem_addr, want_req_addr);
        want_req_chk = 1'b0;
      end
      due = cyc + $urandom_range(k_min, k_max);
      if (pend_due.size() > 0 && due <= pend_due[$]) due = pend_due[$] + 1;
      pend_due.push_back(due);
      pend_addr.push_back(imem_addr);
    end
  end

  // Monitor: compares whatever decode consumes against the reference stream.
  bit          p_rst = 1'b1, p_hold = 1'b0, p_reqw = 1'b0;
  logic [31:0] p_pc = '0, p_ins = '0, p_addr = '0;
  always begin
    @(posedge clk);
    #6;
    if (rst) begin
      check("req_low_in_reset", imem_req, 0);
    end else begin
      if (p_rst) begin
        check("reset_fetch_valid", fetch_valid, 0);
        check("reset_instr", current_instruction, 0);
        check("reset_pc", current_pc, 0);
      end
      if (p_hold) begin
        check("stall_hold_pc", current_pc, p_pc);
        check("stall_hold_instr", current_instruction, p_ins);
      end
      if (p_reqw && !(jump_valid && cond != 0)) begin
        check("req_held", imem_req, 1);
        check("addr_held", imem_addr, p_addr);
      end
      if (fetch_valid && !stall) begin
        n_cons++;
        if (exp_pc_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got pc %h, no word expected (cycle %0d)", current_pc, cyc);
        end else begin
          check("head_pc", current_pc, exp_pc_q.pop_front());
          check("head_instr", current_instruction, exp_ins_q.pop_front());
        end
      end else if (!fetch_valid) begin
        check("nop_instr", current_instruction, 0);
        check("nop_pc", current_pc, 0);
      end
      if (dut.u_buf.push_i)
        check("no_push_into_full", 32'(dut.u_buf.count_o == BUF_DEPTH && !dut.u_buf.pop_i), 0);
    end
    p_rst  = rst;
    p_hold = !rst && fetch_valid && stall;
    p_pc   = current_pc;
    p_ins  = current_instruction;
    p_reqw = !rst && imem_req && !imem_ready;
    p_addr = imem_addr;
  end

  // One cycle of decode-side stimulus; pushes the expected word whenever decode consumes.
  task automatic step(input bit do_rst, input bit force_jump, output bit forced);
    bit taken;
    forced = 1'b0;
    @(posedge clk);
    #2;
    rst = do_rst;
    stall = 1'b0;
    jump_valid = 1'b0;
    cond = '0;
    jaddr = $urandom;
    if (do_rst) begin
      exp_pc_q.delete();
      exp_ins_q.delete();
      model_pc = RESET_PC;
      want_req_addr = RESET_PC;
      want_req_chk = 1'b1;
    end else begin
      if (force_jump && fetch_valid && pend_due.size() > 0) begin
        forced = 1'b1;
        jump_valid = 1'b1;
        cond = 32'h1;
        jaddr = 32'h40;
      end else begin
        stall = ($urandom_range(0, 99) < stall_pct);
        if (!stall && fetch_valid && $urandom_range(0, 99) < jump_pct) begin
          jump_valid = 1'b1;
          taken = ($urandom_range(0, 99) < taken_pct);
          cond = taken ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
          jaddr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 511));
        end
      end
      if (!stall && fetch_valid) begin
        exp_pc_q.push_back(model_pc);
        exp_ins_q.push_back(mem_word(model_pc));
        if (jump_valid && cond != 0) begin
          model_pc = jaddr;
          want_req_addr = jaddr;
          want_req_chk = 1'b1;
        end else begin
          model_pc = model_pc + 32'd1;
        end
      end
    end
  endtask

  task automatic run(input int n);
    bit f;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, f);
  endtask

  // Let any outstanding read complete, then reset.
  task automatic quiesce_reset();
    bit f;
    stall_pct = 0; jump_pct = 0; rdy_pct = 0;
    for (int i = 0; i < 12 && pend_due.size() != 0; i++) step(1'b0, 1'b0, f);
    step(1'b1, 1'b0, f);
  endtask

  initial begin
    bit f;
    bit hit;
    int c0;

    step(1'b1, 1'b0, f);
    step(1'b1, 1'b0, f);

    // Sequential fetch, k=1, ready=1: steady state one word per two cycles
    k_min = 1; k_max = 1; rdy_pct = 100;
    run(10);
    c0 = n_cons;
    run(40);
    check("throughput_40_cycles", n_cons - c0, 20);

    // Stall with a full buffer, then release in order
    quiesce_reset();
    rdy_pct = 100;
    run(3);
    stall_pct = 100;
    run(6);
    stall_pct = 0;
    run(10);

    // Redirect to 0x40 while a request is outstanding (k=3)
    quiesce_reset();
    rdy_pct = 100; k_min = 3; k_max = 3; stall_pct = 50;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) step(1'b0, 1'b1, hit);
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL redirect_setup: no outstanding request with a valid head within 100 cycles");
    end
    stall_pct = 0;
    run(20);

    // Not-taken jumps only
    jump_pct = 40; taken_pct = 0; k_min = 1; k_max = 2;
    run(40);

    // imem_ready low: request and address must hold
    quiesce_reset();
    rdy_pct = 0;
    run(6);
    rdy_pct = 100;
    run(8);

    // Reset while WAIT, stale rvalid lands the cycle after reset
    quiesce_reset();
    rdy_pct = 100; k_min = 2; k_max = 2;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(1'b0, 1'b0, f);
      #1;
      hit = imem_req && imem_ready;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL stale_setup: no accept within 20 cycles");
    end
    step(1'b1, 1'b0, f);
    run(20);

    // Long random mix
    stall_pct = 30; jump_pct = 10; taken_pct = 50; rdy_pct = 70; k_min = 1; k_max = 3;
    c0 = n_cons;
    run(3000);
    stall_pct = 0; jump_pct = 0; rdy_pct = 100;
    run(20);
    check("random_progress", 32'(n_cons - c0 >= 100), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
